// File: rtl/sbus_mem_requester.sv
// MBOX-side SBUS requester: one quad-word read/write per request, per-word ACKN/VALID tracking,
// read parity check and a no-response timeout. Accept -> ADDR -> START -> XFER -> RSP, one request in flight.
module sbus_mem_requester #(
  parameter int ADDR_W  = 22,
  parameter int TIMEOUT = 64
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   reqValid,
  output logic                   reqReady,
  input  logic [ADDR_W-1:0]      reqAddr,
  input  logic [3:0]             reqMask,
  input  logic                   reqRead,
  input  logic                   reqWrite,
  input  logic [3:0][35:0]       reqWData,
  output logic                   startA,
  output logic                   startB,
  output logic                   rdRq,
  output logic                   wrRq,
  output logic [3:0]             rq,
  output logic [ADDR_W-1:0]      adr,
  output logic                   adrHold,
  input  logic                   acknA,
  input  logic                   acknB,
  input  logic                   validInA,
  input  logic                   validInB,
  input  logic [35:0]            dIn,
  input  logic                   parIn,
  output logic [35:0]            dOut,
  output logic                   validOutA,
  output logic                   validOutB,
  output logic                   rspValid,
  output logic [3:0][35:0]       rspData,
  output logic [3:0]             rspParErr,
  output logic                   rspErr
);

  // MBUS address bit 33 (bit 35 is the LSB) carries weight 4 in the word address.
  localparam int PHASE_BIT = 2;

  typedef enum logic [2:0] {IDLE, ADDR, START, XFER, RSP} state_t;

  state_t           state;
  logic             phaseB;
  logic             isRead;
  logic [3:0]       pending;
  logic [3:0][35:0] wdata;
  logic [7:0]       toCnt;

  logic       ackn, valid, consume, parOk;
  logic [1:0] curIdx, nextIdx;
  logic [3:0] pendingNext;

  assign ackn    = phaseB ? acknB : acknA;
  assign valid   = phaseB ? validInB : validInA;
  assign consume = isRead ? valid : ackn;
  assign parOk   = ^{dIn, parIn};

  always_comb begin
    curIdx = 2'd0;
    for (int i = 3; i >= 0; i--)
      if (pending[i]) curIdx = 2'(i);
  end

  assign pendingNext = consume ? (pending & ~(4'b0001 << curIdx)) : pending;

  always_comb begin
    nextIdx = 2'd0;
    for (int i = 3; i >= 0; i--)
      if (pendingNext[i]) nextIdx = 2'(i);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      reqReady  <= 1'b1;
      phaseB    <= 1'b0;
      isRead    <= 1'b0;
      pending   <= '0;
      wdata     <= '0;
      toCnt     <= '0;
      startA    <= 1'b0;
      startB    <= 1'b0;
      rdRq      <= 1'b0;
      wrRq      <= 1'b0;
      rq        <= '0;
      adr       <= '0;
      adrHold   <= 1'b0;
      dOut      <= '0;
      validOutA <= 1'b0;
      validOutB <= 1'b0;
      rspValid  <= 1'b0;
      rspData   <= '0;
      rspParErr <= '0;
      rspErr    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (reqValid && reqReady) begin
            reqReady  <= 1'b0;
            rspData   <= '0;
            rspParErr <= '0;
            phaseB    <= reqAddr[PHASE_BIT];
            isRead    <= reqRead;
            pending   <= reqMask;
            wdata     <= reqWData;
            if (reqRead == reqWrite || reqMask == 4'd0) begin
              // Nothing to put on the bus; only a bad cycle type is an error.
              state    <= RSP;
              rspValid <= 1'b1;
              rspErr   <= (reqRead == reqWrite);
            end else begin
              state   <= ADDR;
              rspErr  <= 1'b0;
              adr     <= reqAddr;
              rq      <= reqMask;
              rdRq    <= reqRead;
              wrRq    <= reqWrite;
              adrHold <= 1'b1;
            end
          end
        end

        ADDR: begin
          adrHold <= 1'b0;
          state   <= START;
          toCnt   <= '0;
          startA  <= ~phaseB;
          startB  <= phaseB;
          if (!isRead) begin
            dOut      <= wdata[curIdx];
            validOutA <= ~phaseB;
            validOutB <= phaseB;
          end
        end

        START, XFER: begin
          if (isRead && valid) begin
            rspData[curIdx]   <= dIn;
            rspParErr[curIdx] <= ~parOk;
          end
          pending <= pendingNext;
          if (pendingNext == 4'd0 || (!(ackn || valid) && toCnt == 8'(TIMEOUT - 1))) begin
            // Completion or abort: drop every request-side line and report.
            state     <= RSP;
            rspValid  <= 1'b1;
            rspErr    <= (pendingNext != 4'd0);
            startA    <= 1'b0;
            startB    <= 1'b0;
            rdRq      <= 1'b0;
            wrRq      <= 1'b0;
            rq        <= '0;
            dOut      <= '0;
            validOutA <= 1'b0;
            validOutB <= 1'b0;
          end else if (ackn || valid) begin
            toCnt <= '0;
            if (!isRead) dOut <= wdata[nextIdx];
            if (ackn) begin
              startA <= 1'b0;
              startB <= 1'b0;
              state  <= XFER;
            end
          end else begin
            toCnt <= toCnt + 8'd1;
          end
        end

        RSP: begin
          rspValid <= 1'b0;
          reqReady <= 1'b1;
          state    <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
